wb_arbiter: RTL and testbench

Parametrised N-master to 1-slave Wishbone B4 (classic and registered-feedback burst) arbiter. Round-robin grant, held for a master's full bus cycle (`cyc` high). Sits between CPU/DMA/debug masters and the shared peripheral bus. Generalises the single-channel bus definition to configurable master count, data width and byte-select width, with full 3-bit CTI / 2-bit BTE and an optional bus watchdog.

---
 rtl/wb_pkg.sv | 39 +++
 rtl/wb_rr_picker.sv | 30 +++
 rtl/wb_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone B4 types and default widths for the arbiter slice.
package wb_pkg;

    localparam int unsigned WB_NUM_MASTERS_DEF = 2;
    localparam int unsigned WB_ADDR_WIDTH_DEF  = 32;
    localparam int unsigned WB_DATA_WIDTH_DEF  = 32;
    localparam int unsigned WB_TIMEOUT_DEF     = 255;
    localparam int unsigned WB_CTI_WIDTH       = 3;
    localparam int unsigned WB_BTE_WIDTH       = 2;
    localparam int unsigned WB_WDOG_WIDTH      = 16;

    // Cycle type identifier
    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_t;

    // Burst type extension
    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_t;

    // Arbiter ownership state
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Index width for a master count, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin select: first requester after 'last', wrapping.
module wb_rr_picker
    import wb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = WB_NUM_MASTERS_DEF,
    localparam int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic                   valid,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W-1:0] cand;

    // Scan last+1 .. last+NUM_MASTERS modulo the master count, keep the first hit
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
            cand = IDX_W'((32'(last) + i) % NUM_MASTERS);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// N-master to 1-slave Wishbone B4 round-robin arbiter; grant held for the
// owner's whole cyc. Optional bus watchdog enabled by WB_ARB_TIMEOUT_EN.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS    = WB_NUM_MASTERS_DEF,
    parameter  int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH_DEF,
    parameter  int unsigned DATA_WIDTH     = WB_DATA_WIDTH_DEF,
    parameter  int unsigned TIMEOUT_CYCLES = WB_TIMEOUT_DEF,
    localparam int unsigned SEL_WIDTH      = DATA_WIDTH / 8,
    localparam int unsigned GRANT_WIDTH    = idx_width(NUM_MASTERS)
) (
    input  logic                                wb_clk,
    input  logic                                wb_rst,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_wb_adr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wb_wdat,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]    m_wb_sel,
    input  logic [NUM_MASTERS-1:0]              m_wb_we,
    input  logic [NUM_MASTERS-1:0]              m_wb_cyc,
    input  logic [NUM_MASTERS-1:0]              m_wb_stb,
    input  logic [NUM_MASTERS*WB_CTI_WIDTH-1:0] m_wb_cti,
    input  logic [NUM_MASTERS*WB_BTE_WIDTH-1:0] m_wb_bte,
    output logic [DATA_WIDTH-1:0]               m_wb_rdat,
    output logic [NUM_MASTERS-1:0]              m_wb_ack,
    output logic [NUM_MASTERS-1:0]              m_wb_err,
    output logic [NUM_MASTERS-1:0]              m_wb_rty,
    output logic [ADDR_WIDTH-1:0]               s_wb_adr,
    output logic [DATA_WIDTH-1:0]               s_wb_wdat,
    output logic [SEL_WIDTH-1:0]                s_wb_sel,
    output logic                                s_wb_we,
    output logic                                s_wb_cyc,
    output logic                                s_wb_stb,
    output logic [WB_CTI_WIDTH-1:0]             s_wb_cti,
    output logic [WB_BTE_WIDTH-1:0]             s_wb_bte,
    input  logic [DATA_WIDTH-1:0]               s_wb_rdat,
    input  logic                                s_wb_ack,
    input  logic                                s_wb_err,
    input  logic                                s_wb_rty,
    output logic [GRANT_WIDTH-1:0]              grant,
    output logic                                busy
);

    // Elaboration-time parameter range checks
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
        $error("wb_arbiter: NUM_MASTERS must be 2..8");
    end
    if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_data_width
        $error("wb_arbiter: DATA_WIDTH must be a multiple of 8 in 8..128");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    // Per-master views of the packed request buses
    logic [ADDR_WIDTH-1:0]   adr_a  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]   wdat_a [NUM_MASTERS];
    logic [SEL_WIDTH-1:0]    sel_a  [NUM_MASTERS];
    logic [WB_CTI_WIDTH-1:0] cti_a  [NUM_MASTERS];
    logic [WB_BTE_WIDTH-1:0] bte_a  [NUM_MASTERS];

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_unpack
        assign adr_a[i]  = m_wb_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdat_a[i] = m_wb_wdat[i*DATA_WIDTH +: DATA_WIDTH];
        assign sel_a[i]  = m_wb_sel[i*SEL_WIDTH +: SEL_WIDTH];
        assign cti_a[i]  = m_wb_cti[i*WB_CTI_WIDTH +: WB_CTI_WIDTH];
        assign bte_a[i]  = m_wb_bte[i*WB_BTE_WIDTH +: WB_BTE_WIDTH];
    end

    arb_state_t             state_q, state_d;
    logic [GRANT_WIDTH-1:0] grant_q, grant_d;
    logic [GRANT_WIDTH-1:0] last_q,  last_d;
    logic                   pick_valid;
    logic [GRANT_WIDTH-1:0] pick_idx;
    logic                   cyc_g;
    logic                   stb_g;
    logic                   timeout_hit;

    assign cyc_g = m_wb_cyc[grant_q];
    assign stb_g = m_wb_stb[grant_q];

    wb_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .req   (m_wb_cyc),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef WB_ARB_TIMEOUT_EN
    logic [WB_WDOG_WIDTH-1:0] wdog_q, wdog_d;
    logic                     term_any;

    assign term_any    = s_wb_ack | s_wb_err | s_wb_rty;
    assign timeout_hit = (state_q == ARB_BUSY) && (wdog_q == WB_WDOG_WIDTH'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // State, ownership and watchdog registers
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GRANT_WIDTH'(NUM_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            wdog_q  <= wdog_d;
`endif
        end
    end

    // Next state: grant on any request in IDLE, release when the owner drops cyc
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (!cyc_g) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
`ifdef WB_ARB_TIMEOUT_EN
        // Count stalled strobes; any termination, timeout or loss of ownership clears
        wdog_d = wdog_q;
        if (state_q != ARB_BUSY || !cyc_g || term_any || timeout_hit) begin
            wdog_d = '0;
        end else if (stb_g) begin
            wdog_d = wdog_q + WB_WDOG_WIDTH'(1);
        end
`endif
    end

    // Outputs: owner's request to the slave, slave response back to the owner only
    always_comb begin
        s_wb_adr  = '0;
        s_wb_wdat = '0;
        s_wb_sel  = '0;
        s_wb_we   = 1'b0;
        s_wb_cyc  = 1'b0;
        s_wb_stb  = 1'b0;
        s_wb_cti  = '0;
        s_wb_bte  = '0;
        m_wb_rdat = '0;
        m_wb_ack  = '0;
        m_wb_err  = '0;
        m_wb_rty  = '0;
        grant     = '0;
        busy      = 1'b0;
        if (!wb_rst) begin
            grant = grant_q;
            if (state_q == ARB_BUSY) begin
                busy      = 1'b1;
                s_wb_adr  = adr_a[grant_q];
                s_wb_wdat = wdat_a[grant_q];
                s_wb_sel  = sel_a[grant_q];
                s_wb_we   = m_wb_we[grant_q];
                s_wb_cyc  = cyc_g;
                s_wb_stb  = stb_g & ~timeout_hit;
                s_wb_cti  = cti_a[grant_q];
                s_wb_bte  = bte_a[grant_q];
                m_wb_rdat = s_wb_rdat;
                // A termination arriving as the owner drops cyc is discarded
                m_wb_ack[grant_q] = s_wb_ack & cyc_g;
                m_wb_err[grant_q] = (s_wb_err | timeout_hit) & cyc_g;
                m_wb_rty[grant_q] = s_wb_rty & cyc_g;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with four masters.
// Watchdog section follows WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter;

    localparam int unsigned NM = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned GW = 2;

    logic               wb_clk = 1'b0;
    logic               wb_rst;
    logic [NM*AW-1:0]   m_adr;
    logic [NM*DW-1:0]   m_wdat;
    logic [NM*SW-1:0]   m_sel;
    logic [NM-1:0]      m_we, m_cyc, m_stb;
    logic [NM*3-1:0]    m_cti;
    logic [NM*2-1:0]    m_bte;
    logic [DW-1:0]      m_rdat;
    logic [NM-1:0]      m_ack, m_err, m_rty;
    logic [AW-1:0]      s_adr;
    logic [DW-1:0]      s_wdat;
    logic [SW-1:0]      s_sel;
    logic               s_we, s_cyc, s_stb;
    logic [2:0]         s_cti;
    logic [1:0]         s_bte;
    logic [DW-1:0]      s_rdat;
    logic               s_ack, s_err, s_rty;
    logic [GW-1:0]      grant;
    logic               busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 wb_clk = ~wb_clk;

    wb_arbiter #(
        .NUM_MASTERS    (NM),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .wb_clk    (wb_clk),
        .wb_rst    (wb_rst),
        .m_wb_adr  (m_adr),
        .m_wb_wdat (m_wdat),
        .m_wb_sel  (m_sel),
        .m_wb_we   (m_we),
        .m_wb_cyc  (m_cyc),
        .m_wb_stb  (m_stb),
        .m_wb_cti  (m_cti),
        .m_wb_bte  (m_bte),
        .m_wb_rdat (m_rdat),
        .m_wb_ack  (m_ack),
        .m_wb_err  (m_err),
        .m_wb_rty  (m_rty),
        .s_wb_adr  (s_adr),
        .s_wb_wdat (s_wdat),
        .s_wb_sel  (s_sel),
        .s_wb_we   (s_we),
        .s_wb_cyc  (s_cyc),
        .s_wb_stb  (s_stb),
        .s_wb_cti  (s_cti),
        .s_wb_bte  (s_bte),
        .s_wb_rdat (s_rdat),
        .s_wb_ack  (s_ack),
        .s_wb_err  (s_err),
        .s_wb_rty  (s_rty),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Drive point: just after the active edge
    task automatic tick();
        @(posedge wb_clk);
        #1;
    endtask

    // Sample point: opposite edge
    task automatic settle();
        @(negedge wb_clk);
    endtask

    task automatic set_master(input int idx, input logic cyc, input logic stb, input logic we,
                              input logic [AW-1:0] adr, input logic [2:0] cti);
        m_cyc[idx]          = cyc;
        m_stb[idx]          = stb;
        m_we[idx]           = we;
        m_adr[idx*AW +: AW] = adr;
        m_cti[idx*3 +: 3]   = cti;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [2:0] burst_cti [4];
        burst_cti[0] = 3'b010; burst_cti[1] = 3'b010; burst_cti[2] = 3'b010; burst_cti[3] = 3'b111;

        wb_rst = 1'b1;
        m_adr = '0; m_wdat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        m_cti = '0; m_bte = '0;
        s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        set_master(0, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 3'b000);
        set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 3'b000);
        m_wdat[0 +: DW] = 32'hCAFE_0001;
        m_sel = '1;
        s_ack = 1'b1;

        // Everything quiet while held in reset, even with requests and an ack present
        tick(); tick(); settle();
        check("rst_s_cyc", 64'(s_cyc), 64'd0);
        check("rst_s_stb", 64'(s_stb), 64'd0);
        check("rst_m_ack", 64'(m_ack), 64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        check("rst_grant", 64'(grant), 64'd0);

        tick(); wb_rst = 1'b0; s_ack = 1'b0;
        settle();
        check("idle_s_cyc", 64'(s_cyc), 64'd0);
        check("idle_s_adr", 64'(s_adr), 64'd0);

        // Master 0 wins the first arbitration
        tick(); settle();
        check("first_grant", 64'(grant), 64'd0);
        check("first_busy",  64'(busy),  64'd1);
        check("first_s_cyc", 64'(s_cyc), 64'd1);
        check("first_s_adr", 64'(s_adr), 64'h1000);
        check("first_s_we",  64'(s_we),  64'd1);

        tick(); s_ack = 1'b1; settle();
        check("m0_ack",    64'(m_ack),  64'b0001);
        check("m0_s_wdat", 64'(s_wdat), 64'hCAFE_0001);

        // Master 0 drops cyc with ack present: ack discarded, bus released
        tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0; settle();
        check("drop_ack",   64'(m_ack), 64'd0);
        check("drop_s_cyc", 64'(s_cyc), 64'd0);

        tick(); s_ack = 1'b0; settle();
        check("dead_busy",  64'(busy),  64'd0);
        check("dead_s_cyc", 64'(s_cyc), 64'd0);

        tick(); settle();
        check("m1_grant", 64'(grant), 64'd1);
        check("m1_s_adr", 64'(s_adr), 64'h2000);
        s_rdat = 32'hDEAD_BEEF;
        check("m1_wait_ack", 64'(m_ack), 64'd0);

        tick(); s_ack = 1'b1; settle();
        check("m1_read_ack",  64'(m_ack),  64'b0010);
        check("m1_read_rdat", 64'(m_rdat), 64'hDEAD_BEEF);

        // Master 1 ends; master 0 opens a burst, master 1 requests again
        tick(); s_ack = 1'b0;
        set_master(1, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 3'b000);
        set_master(0, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 3'b010);
        settle();
        check("m1_release_grant", 64'(grant), 64'd1);

        tick(); set_master(1, 1'b1, 1'b1, 1'b0, 32'h0000_2100, 3'b010); settle();
        check("pre_burst_busy", 64'(busy), 64'd0);

        tick(); settle();
        check("burst_grant", 64'(grant), 64'd0);

        for (int b = 0; b < 4; b++) begin
            tick();
            m_cti[0 +: 3] = burst_cti[b];
            m_adr[0 +: AW] = 32'h0000_3000 + 32'(4 * b);
            s_ack = 1'b1;
            settle();
            check($sformatf("burst_ack%0d", b),   64'(m_ack), 64'b0001);
            check($sformatf("burst_cti%0d", b),   64'(s_cti), 64'(burst_cti[b]));
            check($sformatf("burst_grant%0d", b), 64'(grant), 64'd0);
        end

        tick(); m_cyc[0] = 1'b0; m_stb[0] = 1'b0; s_ack = 1'b0; settle();
        check("burst_end_grant", 64'(grant), 64'd0);
        tick(); settle();
        check("burst_end_busy", 64'(busy), 64'd0);
        tick(); settle();
        check("after_burst_grant", 64'(grant), 64'd1);

        // Reset in the middle of master 1's burst
        tick(); s_ack = 1'b1; settle();
        check("m1_beat_ack", 64'(m_ack), 64'b0010);
        tick(); wb_rst = 1'b1; m_cyc = 4'b1111; m_stb = 4'b1111; settle();
        check("mid_rst_s_cyc", 64'(s_cyc), 64'd0);
        check("mid_rst_busy",  64'(busy),  64'd0);
        check("mid_rst_grant", 64'(grant), 64'd0);
        check("mid_rst_ack",   64'(m_ack), 64'd0);

        tick(); wb_rst = 1'b0; s_ack = 1'b0; settle();
        check("post_rst_busy", 64'(busy), 64'd0);

        // All four requesting: strict rotation from master 0
        tick();
        for (int i = 0; i < 8; i++) begin
            int g;
            g = i % 4;
            settle();
            check($sformatf("rot%0d_grant", i), 64'(grant), 64'(g));
            check($sformatf("rot%0d_busy", i),  64'(busy),  64'd1);
            tick(); m_cyc[g] = 1'b0;
            tick(); m_cyc[g] = 1'b1;
            tick();
        end

        // Single requester with a slave that never answers
        tick(); m_cyc = '0; m_stb = '0;
        tick(); m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
        tick(); settle();
        check("stall_grant", 64'(grant), 64'd2);
`ifdef WB_ARB_TIMEOUT_EN
        for (int n = 0; n < 16; n++) begin
            if (n > 0) settle();
            check($sformatf("stall%0d_err", n), 64'(m_err), 64'd0);
            @(posedge wb_clk);
        end
        settle();
        check("timeout_err", 64'(m_err), 64'b0100);
        check("timeout_stb", 64'(s_stb), 64'd0);
        @(posedge wb_clk);
        settle();
        check("after_timeout_err", 64'(m_err), 64'd0);
        check("after_timeout_stb", 64'(s_stb), 64'd1);
`else
        for (int n = 0; n < 20; n++) begin
            if (n > 0) settle();
            check($sformatf("hang%0d_err", n), 64'(m_err), 64'd0);
            check($sformatf("hang%0d_stb", n), 64'(s_stb), 64'd1);
            @(posedge wb_clk);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
